// File: rtl/sobel_pkg.sv
// Shared widths, latency and helpers for the Sobel edge-magnitude datapath.
package sobel_pkg;

  localparam int PIX_W     = 8;
  localparam int PSUM_W    = 10;
  localparam int GRAD_W    = 11;
  localparam int SUM_W     = 11;
  localparam int SOBEL_LAT = 3;

  // Clamp the |Gx|+|Gy| sum into an 8-bit pixel; never wraps.
  function automatic logic [PIX_W-1:0] sat8(input logic [SUM_W-1:0] s);
    logic [PIX_W-1:0] r;
    if (s > SUM_W'(255)) begin
      r = '1;
    end else begin
      r = s[PIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_121_sum.sv
// Combinational 1-2-1 weighted sum of three pixels: a + 2*b + c.
module sobel_121_sum
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0]  a,
  input  logic [PIX_W-1:0]  b,
  input  logic [PIX_W-1:0]  c,
  output logic [PSUM_W-1:0] sum
);

  logic [PSUM_W-1:0] a_ext;
  logic [PSUM_W-1:0] b_dbl;
  logic [PSUM_W-1:0] c_ext;

  assign a_ext = PSUM_W'(a);
  assign b_dbl = PSUM_W'({b, 1'b0});
  assign c_ext = PSUM_W'(c);

  // Max 255 + 510 + 255 = 1020, which fits the 10-bit result exactly.
  assign sum = a_ext + b_dbl + c_ext;

endmodule

// File: rtl/sobel_calc.sv
// Three-stage pipelined 3x3 Sobel engine: one window in, one saturated
// |Gx|+|Gy| magnitude out per clock.
module sobel_calc
  import sobel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] d0_i,
  input  logic [PIX_W-1:0] d1_i,
  input  logic [PIX_W-1:0] d2_i,
  input  logic [PIX_W-1:0] d3_i,
  input  logic [PIX_W-1:0] d4_i,
  input  logic [PIX_W-1:0] d5_i,
  input  logic [PIX_W-1:0] d6_i,
  input  logic [PIX_W-1:0] d7_i,
  input  logic [PIX_W-1:0] d8_i,
  input  logic             done_i,
  output logic [PIX_W-1:0] grayscale_o,
  output logic             done_o
);

  // Qualifier semantics: done_i marks the d*_i set of this cycle as a real
  // window; it rides a shift chain alongside the data and emerges as done_o
  // exactly SOBEL_LAT cycles later. No ready/stall exists: the sink must take
  // every result. Data registers run every cycle regardless of done_i.

  logic [PSUM_W-1:0] gxp_sum, gxn_sum, gyp_sum, gyn_sum;

  sobel_121_sum u_gxp (.a(d0_i), .b(d3_i), .c(d6_i), .sum(gxp_sum));
  sobel_121_sum u_gxn (.a(d2_i), .b(d5_i), .c(d8_i), .sum(gxn_sum));
  sobel_121_sum u_gyp (.a(d0_i), .b(d1_i), .c(d2_i), .sum(gyp_sum));
  sobel_121_sum u_gyn (.a(d6_i), .b(d7_i), .c(d8_i), .sum(gyn_sum));

  // Stage 1: partial sums
  logic [PSUM_W-1:0] gxp_q, gxn_q, gyp_q, gyn_q;
  logic              v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gxp_q <= '0;
      gxn_q <= '0;
      gyp_q <= '0;
      gyn_q <= '0;
      v1    <= 1'b0;
    end else begin
      gxp_q <= gxp_sum;
      gxn_q <= gxn_sum;
      gyp_q <= gyp_sum;
      gyn_q <= gyn_sum;
      v1    <= done_i;
    end
  end

  // Stage 2 combinational: signed gradients and their magnitudes
  logic signed [GRAD_W-1:0] gx, gy;
  logic        [GRAD_W-1:0] gx_mag, gy_mag;

  always_comb begin
    gx     = $signed({1'b0, gxp_q}) - $signed({1'b0, gxn_q});
    gy     = $signed({1'b0, gyp_q}) - $signed({1'b0, gyn_q});
    gx_mag = gx[GRAD_W-1] ? -gx : gx;
    gy_mag = gy[GRAD_W-1] ? -gy : gy;
  end

  logic [PSUM_W-1:0] abs_x_q, abs_y_q;
  logic              v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_x_q <= '0;
      abs_y_q <= '0;
      v2      <= 1'b0;
    end else begin
      abs_x_q <= gx_mag[PSUM_W-1:0];
      abs_y_q <= gy_mag[PSUM_W-1:0];
      v2      <= v1;
    end
  end

  // Stage 3: sum and saturate
  logic [SUM_W-1:0] mag_sum;

  assign mag_sum = SUM_W'(abs_x_q) + SUM_W'(abs_y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grayscale_o <= '0;
      done_o      <= 1'b0;
    end else begin
      grayscale_o <= sat8(mag_sum);
      done_o      <= v2;
    end
  end

  // d4 has zero kernel weight; magnitude MSBs are always 0 (|G| <= 1020).
  logic unused_bits;
  assign unused_bits = ^{d4_i, gx_mag[GRAD_W-1], gy_mag[GRAD_W-1]};

endmodule

// File: tb/tb_sobel_calc.sv
// Self-checking bench for sobel_calc: scoreboard of expected {done, pixel}
// plus directed scenarios with fixed known answers.
module tb_sobel_calc;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic [7:0] d5 = '0, d6 = '0, d7 = '0, d8 = '0;
  logic       done_i = 1'b0;
  logic [7:0] grayscale_o;
  logic       done_o;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  sobel_calc dut (
    .clk(clk), .rst(rst),
    .d0_i(d0), .d1_i(d1), .d2_i(d2), .d3_i(d3), .d4_i(d4),
    .d5_i(d5), .d6_i(d6), .d7_i(d7), .d8_i(d8),
    .done_i(done_i), .grayscale_o(grayscale_o), .done_o(done_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [7:0] ref_sobel(input logic [71:0] w);
    int p[9];
    int gx, gy, m;
    for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
    gx = (p[0] + 2*p[3] + p[6]) - (p[2] + 2*p[5] + p[8]);
    gy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    if (m > 255) m = 255;
    return m[7:0];
  endfunction

  function automatic logic [71:0] win9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [71:0] w;
    w = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return w;
  endfunction

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) begin
      case ($urandom_range(0, 3))
        0:       w[8*i +: 8] = 8'd0;
        1:       w[8*i +: 8] = 8'd255;
        default: w[8*i +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return w;
  endfunction

  // Driver tasks
  task automatic set_inputs(input logic [71:0] w, input logic dn);
    d0 = w[7:0];   d1 = w[15:8];  d2 = w[23:16];
    d3 = w[31:24]; d4 = w[39:32]; d5 = w[47:40];
    d6 = w[55:48]; d7 = w[63:56]; d8 = w[71:64];
    done_i = dn;
  endtask

  task automatic drive(input logic [71:0] w, input logic dn);
    set_inputs(w, dn);
    exp_q.push_back({dn, ref_sobel(w)});
  endtask

  // Scoreboard: entry driven at negedge k is visible after posedge k+2
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (!rst && exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      tests++;
      if ({done_o, grayscale_o} !== e) begin
        fails++;
        $display("FAIL scoreboard: got done_o=%0b grayscale_o=%0d, expected done_o=%0b grayscale_o=%0d",
                 done_o, grayscale_o, e[8], e[7:0]);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_inputs(rand_win(), 1'b1);
      tests++;
      if (grayscale_o !== 8'd0 || done_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: got grayscale_o=%0d done_o=%0b, expected 0/0", grayscale_o, done_o);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(rand_win(), 1'b0);
  endtask

  task automatic test_single(input string name, input logic [71:0] w, input logic [7:0] want);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      if (i == LAT) begin
        tests++;
        if (grayscale_o !== want || done_o !== 1'b1) begin
          fails++;
          $display("FAIL %s: got grayscale_o=%0d done_o=%0b, expected %0d/1", name, grayscale_o, done_o, want);
        end
      end
      drive(w, 1'b1);
    end
    @(negedge clk);
    drive(w, 1'b0);
  endtask

  task automatic test_stream_reset();
    logic [71:0] w_tab[7];
    logic        d_tab[7];
    logic [7:0]  g_tab[4];
    w_tab[0] = win9(1, 2, 3, 4, 5, 6, 7, 8, 9);            d_tab[0] = 1'b1;
    w_tab[1] = win9(100, 100, 100, 100, 100, 100, 100, 100, 100); d_tab[1] = 1'b0;
    w_tab[2] = win9(255, 255, 255, 255, 0, 0, 255, 0, 0);  d_tab[2] = 1'b1;
    w_tab[3] = win9(0, 0, 10, 0, 0, 10, 0, 0, 10);         d_tab[3] = 1'b1;
    w_tab[4] = win9(10, 0, 0, 10, 0, 0, 10, 0, 0);         d_tab[4] = 1'b1;
    w_tab[5] = rand_win();                                 d_tab[5] = 1'b1;
    w_tab[6] = rand_win();                                 d_tab[6] = 1'b1;
    g_tab[0] = 8'd32; g_tab[1] = 8'd0; g_tab[2] = 8'd255; g_tab[3] = 8'd40;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        tests++;
        if (grayscale_o !== g_tab[i-LAT] || done_o !== d_tab[i-LAT]) begin
          fails++;
          $display("FAIL stream[%0d]: got grayscale_o=%0d done_o=%0b, expected %0d/%0b",
                   i-LAT, grayscale_o, done_o, g_tab[i-LAT], d_tab[i-LAT]);
        end
      end
      drive(w_tab[i], d_tab[i]);
    end
    @(posedge clk);
    #3;
    tests++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_done: got done_o=%0b, expected 1", done_o);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    tests++;
    if (done_o !== 1'b0 || grayscale_o !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got done_o=%0b grayscale_o=%0d, expected 0/0", done_o, grayscale_o);
    end
    repeat (2) begin
      @(negedge clk);
      set_inputs(rand_win(), 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(rand_win(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (done_o !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle[%0d]: got done_o=%0b, expected 0", i, done_o);
      end
      drive(rand_win(), 1'b0);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(rand_win(), 1'(i % 2));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(rand_win(), 1'($urandom_range(0, 1)));
    end
    repeat (LAT + 1) begin
      @(negedge clk);
      drive(rand_win(), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single("ramp", win9(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd32);
    test_single("flat", win9(100, 100, 100, 100, 100, 100, 100, 100, 100), 8'd0);
    test_single("saturate", win9(255, 255, 255, 255, 0, 0, 255, 0, 0), 8'd255);
    test_single("edge_right", win9(0, 0, 10, 0, 0, 10, 0, 0, 10), 8'd40);
    test_single("edge_left", win9(10, 0, 0, 10, 0, 0, 10, 0, 0), 8'd40);
    test_single("all_255", win9(255, 255, 255, 255, 255, 255, 255, 255, 255), 8'd0);
    test_stream_reset();
    test_toggle();
    test_back_to_back();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
